// File: rtl/tacho_multi_if.sv
// CSR bus bundle for tacho_multi: address, write data/strobe and combinational read data.
interface tacho_multi_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (output csr_a, csr_di, csr_we, input csr_do);
  modport slave  (input csr_a, csr_di, csr_we, output csr_do);
endinterface

// File: rtl/tacho_multi.sv
// Multi-channel fan tachometer: per-channel pulse counters snapshotted on ce_1hz,
// overflow/stall sticky status with W1C clear and a registered interrupt.
module tacho_multi #(
  parameter logic [4:0] BASE_ADDR = 5'h0,
  parameter int         NUM_CH    = 2,
  parameter int         CNT_W     = 12,
  parameter int         STALL_SEC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  tacho_multi_if.slave      csr,
  input  logic              ce_1hz,
  input  logic [NUM_CH-1:0] tacho_in,
  output logic              irq
);

  localparam logic [3:0]       CH_MASK   = 4'((1 << NUM_CH) - 1);
  localparam logic [4:0]       LAST_OFF  = 5'(2 + 2 * NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [2:0]       STALL_MAX = 3'(STALL_SEC);

  logic [3:0] en_reg;
  logic       hold_reg;
  logic [3:0] ie_reg;
  logic [3:0] ovf_reg;
  logic [3:0] stall_reg;
  logic       irq_reg;

  logic [3:0]       ovf_set;
  logic [3:0]       stall_set;
  logic [3:0]       ovf_next;
  logic [3:0]       stall_next;
  logic [7:0]       w1c_mask;
  logic [3:0][15:0] snap_rd;

  logic [5:0] off_full;
  logic [4:0] off_addr;
  logic       in_range;
  logic       wr_ctrl0;
  logic       wr_ctrl1;
  logic       wr_status;
  logic [7:0] rd_data;

  // Offset computed one bit wider so addresses below BASE_ADDR show up as negative.
  assign off_full  = {1'b0, csr.csr_a} - {1'b0, BASE_ADDR};
  assign off_addr  = off_full[4:0];
  assign in_range  = !off_full[5] && (off_addr <= LAST_OFF);
  assign wr_ctrl0  = csr.csr_we && in_range && (off_addr == 5'd0);
  assign wr_ctrl1  = csr.csr_we && in_range && (off_addr == 5'd1);
  assign wr_status = csr.csr_we && in_range && (off_addr == 5'd2);

  assign w1c_mask   = wr_status ? csr.csr_di : 8'h00;
  // Set events are OR-ed in after the clear so a same-cycle set survives a W1C.
  assign ovf_next   = ((ovf_reg & ~w1c_mask[7:4]) | ovf_set) & CH_MASK;
  assign stall_next = ((stall_reg & ~w1c_mask[3:0]) | stall_set) & CH_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg    <= 4'h0;
      hold_reg  <= 1'b0;
      ie_reg    <= 4'h0;
      ovf_reg   <= 4'h0;
      stall_reg <= 4'h0;
      irq_reg   <= 1'b0;
    end else begin
      if (wr_ctrl0) begin
        en_reg   <= csr.csr_di[3:0] & CH_MASK;
        hold_reg <= csr.csr_di[4];
      end
      if (wr_ctrl1) begin
        ie_reg <= csr.csr_di[3:0] & CH_MASK;
      end
      ovf_reg   <= ovf_next;
      stall_reg <= stall_next;
      irq_reg   <= |((ovf_reg | stall_reg) & ie_reg);
    end
  end

  assign irq = irq_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      if (gi < NUM_CH) begin : g_on
        logic [2:0]       sync_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] snap_reg;
        logic [2:0]       stall_cnt_reg;
        logic             armed_reg;
        logic             ev;

        // sync_reg[1] is the synchronised level, sync_reg[2] its previous value.
        assign ev = sync_reg[2] & ~sync_reg[1];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sync_reg <= 3'b000;
          end else begin
            sync_reg <= {sync_reg[1:0], tacho_in[gi]};
          end
        end

        // armed_reg discards the partial window between enable and the first ce_1hz.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cnt_reg       <= '0;
            snap_reg      <= '0;
            stall_cnt_reg <= 3'd0;
            armed_reg     <= 1'b0;
          end else if (!en_reg[gi]) begin
            cnt_reg       <= '0;
            snap_reg      <= '0;
            stall_cnt_reg <= 3'd0;
            armed_reg     <= 1'b0;
          end else if (ce_1hz) begin
            cnt_reg   <= ev ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            armed_reg <= 1'b1;
            if (armed_reg && !hold_reg) begin
              snap_reg <= cnt_reg;
            end
            if (cnt_reg == '0) begin
              if (stall_cnt_reg < STALL_MAX) begin
                stall_cnt_reg <= stall_cnt_reg + 3'd1;
              end
            end else begin
              stall_cnt_reg <= 3'd0;
            end
          end else if (ev && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        assign ovf_set[gi]   = en_reg[gi] & ev & ~ce_1hz & (cnt_reg == CNT_MAX);
        assign stall_set[gi] = en_reg[gi] & ce_1hz & (cnt_reg == '0) &
                               (stall_cnt_reg == STALL_MAX - 3'd1);
        assign snap_rd[gi]   = 16'(snap_reg);
      end else begin : g_off
        assign ovf_set[gi]   = 1'b0;
        assign stall_set[gi] = 1'b0;
        assign snap_rd[gi]   = 16'h0000;
      end
    end
  endgenerate

  always_comb begin
    rd_data = 8'h00;
    if (in_range) begin
      case (off_addr)
        5'd0: rd_data = {3'b000, hold_reg, en_reg};
        5'd1: rd_data = {4'b0000, ie_reg};
        5'd2: rd_data = {ovf_reg, stall_reg};
        default: begin
          for (int c = 0; c < 4; c++) begin
            if (off_addr == 5'(3 + 2 * c)) rd_data = snap_rd[c][7:0];
            if (off_addr == 5'(4 + 2 * c)) rd_data = snap_rd[c][15:8];
          end
        end
      endcase
    end
  end

  assign csr.csr_do = rd_data;

endmodule
